prefetch_fetcher: RTL and testbench

Parametrised successor to the single-byte fetcher. It streams bytes from the synchronous program memory into a DEPTH-entry byte queue and assembles complete 6502 instructions of 1 to 3 bytes. It presents them to the decoder with a valid/ready handshake. It sits between mem and decoder, owns the fetch address, and accepts PC redirects from branch and jump logic.

---
 rtl/prefetch_fetcher_pkg.sv | 8 +
 rtl/prefetch_fetcher_if.sv | 27 ++
 rtl/prefetch_fetcher_opcode_len.sv | 15 +
 rtl/prefetch_fetcher.sv | 72 +++++++
 tb/tb_prefetch_fetcher.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_fetcher_pkg.sv
// prefetch_fetcher_pkg: shared widths and types for the fetch/decode front end
package prefetch_fetcher_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH = 8;
  localparam int ILEN_WIDTH = 2;
  localparam int PREFETCH_DEPTH = 4;
  typedef logic [ILEN_WIDTH-1:0] ilen_t;
endpackage

// File: rtl/prefetch_fetcher_if.sv
// prefetch_fetcher_if: memory read port, redirect and instruction handshake bundle
interface prefetch_fetcher_if #(
  parameter int AW = prefetch_fetcher_pkg::ADDR_WIDTH,
  parameter int DW = prefetch_fetcher_pkg::REG_WIDTH
);
  import prefetch_fetcher_pkg::*;
  logic mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic pc_load;
  logic [AW-1:0] pc_load_value;
  logic instr_valid;
  logic instr_ready;
  logic [DW-1:0] instr_opcode;
  logic [DW-1:0] instr_op1;
  logic [DW-1:0] instr_op2;
  ilen_t instr_len;
  logic [AW-1:0] instr_pc;
  modport master (
    output mem_re, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2, instr_len, instr_pc,
    input mem_rdata, pc_load, pc_load_value, instr_ready
  );
  modport slave (
    input mem_re, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2, instr_len, instr_pc,
    output mem_rdata, pc_load, pc_load_value, instr_ready
  );
endinterface

// File: rtl/prefetch_fetcher_opcode_len.sv
// opcode_len: 6502 instruction length (1..3 bytes) from its opcode
module opcode_len
  import prefetch_fetcher_pkg::*;
(
  input logic [REG_WIDTH-1:0] opcode,
  output ilen_t len
);
  logic [3:0] lo;
  assign lo = opcode[3:0];
  // absolute/indirect forms take two operand bytes; implied/accumulator forms none
  always_comb begin
    len = (opcode == 8'h20 || lo inside {4'hC, 4'hD, 4'hE} || (lo == 4'h9 && opcode[4])) ? 2'd3 :
          (opcode inside {8'h00, 8'h40, 8'h60} || lo == 4'h8 || lo == 4'hA) ? 2'd1 : 2'd2;
  end
endmodule

// File: rtl/prefetch_fetcher.sv
// prefetch_fetcher: byte prefetch queue assembling whole 6502 instructions for the decoder
module prefetch_fetcher #(
  parameter int ADDR_WIDTH = prefetch_fetcher_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = prefetch_fetcher_pkg::REG_WIDTH,
  parameter int DEPTH = prefetch_fetcher_pkg::PREFETCH_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset_n,
  prefetch_fetcher_if.master bus
);
  import prefetch_fetcher_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data [DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
  logic [ADDR_WIDTH-1:0] nxt_addr [DEPTH];
  logic [CW-1:0] count, nxt_count;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic inflight, valid, pop, push;
  ilen_t head_len, pop_len;
  if (DEPTH < 3 || DEPTH > 16) begin : g_depth_check
    $fatal(1, "prefetch_fetcher: DEPTH must be in 3..16");
  end
  opcode_len u_len (.opcode(q_data[0]), .len(head_len));
  // handshake, read issue and zero-gated instruction fields; redirect suppresses both issue and pop
  always_comb begin
    valid = count != '0 && count >= CW'(head_len);
    pop = valid && bus.instr_ready && !bus.pc_load;
    pop_len = pop ? head_len : '0;
    push = inflight && !bus.pc_load;
    bus.mem_re = reset_n && !bus.pc_load && (int'(count) + int'(inflight) < DEPTH);
    bus.mem_addr = fetch_pc;
    bus.instr_valid = valid;
    bus.instr_opcode = valid ? q_data[0] : '0;
    bus.instr_op1 = valid && head_len >= 2'd2 ? q_data[1] : '0;
    bus.instr_op2 = valid && head_len == 2'd3 ? q_data[2] : '0;
    bus.instr_len = valid ? head_len : '0;
    bus.instr_pc = valid ? q_addr[0] : '0;
  end
  // shift out the popped instruction and append the returning byte behind the survivors
  always_comb begin
    nxt_count = count - CW'(pop_len) + CW'(push);
    for (int i = 0; i < DEPTH; i++) begin
      nxt_data[i] = '0;
      nxt_addr[i] = '0;
      if (i + int'(pop_len) < int'(count)) begin
        nxt_data[i] = q_data[IW'(i + int'(pop_len))];
        nxt_addr[i] = q_addr[IW'(i + int'(pop_len))];
      end else if (push && i == int'(count) - int'(pop_len)) begin
        nxt_data[i] = bus.mem_rdata;
        nxt_addr[i] = fetch_pc - ADDR_WIDTH'(1);
      end
    end
  end
  // queue state; the in-flight byte's address is fetch_pc-1 since the pc advanced at issue
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q_data <= '{default: '0};
      q_addr <= '{default: '0};
      count <= '0;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      q_data <= nxt_data;
      q_addr <= nxt_addr;
      count <= bus.pc_load ? '0 : nxt_count;
      inflight <= bus.mem_re;
      fetch_pc <= bus.pc_load ? bus.pc_load_value : bus.mem_re ? fetch_pc + ADDR_WIDTH'(1) : fetch_pc;
    end
endmodule

// File: tb/tb_prefetch_fetcher.sv
// tb_prefetch_fetcher: scoreboard bench with a sequential-program reference model
module tb_prefetch_fetcher;
  import prefetch_fetcher_pkg::*;
  typedef struct packed {
    logic [1:0] len;
    logic [7:0] op, o1, o2;
    logic [15:0] pc;
  } ins_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] mem [65536];
  ins_t exp_q [$];
  ins_t e;
  int checks = 0, failures = 0, transfers = 0, stall = 0;
  logic [7:0] ol_op;
  ilen_t ol_len;
  prefetch_fetcher_if bus ();
  prefetch_fetcher #(.RESET_PC(16'h0010)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  opcode_len u_ol (.opcode(ol_op), .len(ol_len));
  always #5 clk = ~clk;
  // synchronous program memory: one-cycle read latency, garbage when idle
  always @(posedge clk) bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : 8'($urandom);
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    logic [3:0] hi, lo;
    hi = op[7:4];
    lo = op[3:0];
    if (op == 8'h20 || lo == 4'hC || lo == 4'hD || lo == 4'hE || (lo == 4'h9 && hi[0])) return 2'd3;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60 || lo == 4'h8 || lo == 4'hA) return 2'd1;
    return 2'd2;
  endfunction
  function automatic ins_t at_addr(input logic [15:0] a);
    ins_t r;
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    r.pc = a;
    r.op = mem[a];
    r.len = ref_len(r.op);
    r.o1 = r.len > 2'd1 ? mem[a1] : 8'h00;
    r.o2 = r.len > 2'd2 ? mem[a2] : 8'h00;
    return r;
  endfunction
  task automatic refill(input logic [15:0] start);
    logic [15:0] a;
    ins_t r;
    a = start;
    exp_q.delete();
    repeat (64) begin
      r = at_addr(a);
      exp_q.push_back(r);
      a = a + 16'(r.len);
    end
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [15:0] v);
    bus.pc_load = 1'b1;
    bus.pc_load_value = v;
    refill(v);
  endtask
  function automatic ins_t head_fields();
    ins_t r;
    r.len = bus.instr_len;
    r.op = bus.instr_opcode;
    r.o1 = bus.instr_op1;
    r.o2 = bus.instr_op2;
    r.pc = bus.instr_pc;
    return r;
  endfunction
  task automatic reset_pulse();
    reset_n = 1'b0;
    bus.pc_load = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_outputs", {bus.mem_re, bus.mem_addr, bus.instr_valid, head_fields()}, {1'b0, 16'h0010, 1'b0, 42'h0});
    tick();
    tick();
    reset_n = 1'b1;
    refill(16'h0010);
  endtask
  // monitor: pop the scoreboard on every transfer, idle fields must be zero, fetch must make progress
  always @(negedge clk) begin
    if (!reset_n) stall = 0;
    else if (bus.pc_load) begin
      stall = 0;
      chk("no_issue_on_load", bus.mem_re, 1'b0);
    end else begin
      stall = bus.instr_valid ? 0 : stall + 1;
      chk("progress", stall > 6, 1'b0);
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty got=%0h", head_fields());
        end else begin
          e = exp_q.pop_front();
          chk("xfer", head_fields(), e);
          transfers++;
        end
      end else if (!bus.instr_valid) chk("idle_zero", head_fields(), 42'h0);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int t0, seg;
    logic [7:0] prog [8];
    prog = '{8'hA9, 8'h04, 8'h85, 8'h02, 8'hEA, 8'h4C, 8'h10, 8'h00};
    bus.pc_load = 1'b0;
    bus.pc_load_value = '0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = prog[i];
    mem[16'hFFFF] = 8'hEA;
    mem[16'h0000] = 8'hA9;
    mem[16'h0001] = 8'h07;
    for (int i = 0; i < 256; i++) begin
      ol_op = 8'(i);
      #1;
      chk("opcode_len", ol_len, ref_len(8'(i)));
    end
    @(negedge clk);
    chk("rst_outputs", {bus.mem_re, bus.mem_addr, bus.instr_valid, head_fields()}, {1'b0, 16'h0010, 1'b0, 42'h0});
    tick();
    reset_n = 1'b1;
    refill(16'h0010);
    t0 = transfers;
    @(negedge clk);
    chk("first_read", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h0010});
    tick();
    tick();
    @(negedge clk);
    chk("not_yet_valid", bus.instr_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("first_instr", {bus.instr_valid, head_fields()}, {1'b1, 2'd2, 8'hA9, 8'h04, 8'h00, 16'h0010});
    repeat (12) tick();
    chk("stream_xfers", transfers - t0 >= 4, 1'b1);
    bus.instr_ready = 1'b0;
    reset_pulse();
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("full_stop", {bus.mem_re, bus.mem_addr}, {1'b0, 16'h0014});
    repeat (4) tick();
    @(negedge clk);
    chk("full_hold", {bus.mem_re, bus.mem_addr, bus.instr_valid, head_fields()},
        {1'b0, 16'h0014, 1'b1, 2'd2, 8'hA9, 8'h04, 8'h00, 16'h0010});
    tick();
    chk("pre_rst_valid", bus.instr_valid, 1'b1);
    reset_pulse();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("restart_read", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h0010});
    repeat (3) tick();
    redirect(16'h0015);
    @(negedge clk);
    chk("load_no_read", bus.mem_re, 1'b0);
    tick();
    bus.pc_load = 1'b0;
    @(negedge clk);
    chk("load_target_read", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h0015});
    repeat (3) tick();
    @(negedge clk);
    chk("load_not_valid", bus.instr_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("load_instr", {bus.instr_valid, head_fields()}, {1'b1, 2'd3, 8'h4C, 8'h10, 8'h00, 16'h0015});
    tick();
    redirect(16'hFFFF);
    tick();
    bus.pc_load = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("wrap_instr", {bus.instr_valid, head_fields()}, {1'b1, 2'd1, 8'hEA, 8'h00, 8'h00, 16'hFFFF});
    repeat (8) tick();
    t0 = transfers;
    seg = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      bus.pc_load = 1'b0;
      bus.instr_ready = ($urandom % 4) != 0;
      seg++;
      if ($urandom % 100 < 5 || seg > 40) begin
        redirect(16'($urandom));
        seg = 0;
      end else if ($urandom % 200 == 0) begin
        reset_pulse();
        seg = 0;
      end
    end
    tick();
    bus.pc_load = 1'b0;
    repeat (4) tick();
    chk("random_xfers", transfers - t0 > 100, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
